// File: rtl/sprdma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprdma_pkg : shared types and constants for the sprite DMA sequencer       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sprdma_pkg;

  typedef enum logic [1:0] {
    ST_CTRL = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spr_state_t;

  localparam logic [1:0] c_reg_pos  = 2'b00;
  localparam logic [1:0] c_reg_ctl  = 2'b01;
  localparam logic [1:0] c_reg_data = 2'b10;
  localparam logic [1:0] c_reg_datb = 2'b11;

  localparam logic [8:0] c_slot_a_ofs  = 9'd0;
  localparam logic [8:0] c_slot_b_ofs  = 9'd2;
  localparam logic [8:0] c_slot_stride = 9'd4;

endpackage
`default_nettype wire

// File: rtl/sprdma_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprdma_chan : one sprite channel - fetch state, vertical window, pointer   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sprdma_chan
  import sprdma_pkg::*;
#(
  parameter logic [8:0] VBL_END = 9'd25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_line_eval,
  input  logic [8:0]  i_vpos,
  input  logic        i_fetch,
  input  logic        i_ptr_wr_lo,
  input  logic        i_ptr_wr_hi,
  input  logic [15:0] i_ptr_data,
  input  logic        i_ack,
  input  logic [1:0]  i_ack_code,
  input  logic [15:0] i_ack_data,
  output spr_state_t  o_state,
  output logic [18:0] o_ptr
);

  spr_state_t  r_state;
  spr_state_t  w_state_nxt;
  logic [8:0]  r_vstart;
  logic [8:0]  r_vstop;
  logic        r_pos_zero;
  logic [18:0] r_ptr;
  logic        w_unused;

  assign w_unused = i_ptr_data[15];
  assign o_state  = r_state;
  assign o_ptr    = r_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_DONE;
    else          r_state <= w_state_nxt;
  end

  // Line evaluation is applied last so a VBL restart overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (i_ack && (r_state == ST_CTRL) && (i_ack_code == c_reg_ctl))
      w_state_nxt = (r_pos_zero && (i_ack_data == 16'h0000)) ? ST_DONE : ST_WAIT;
    if (i_line_eval) begin
      if (i_vpos == VBL_END)
        w_state_nxt = ST_CTRL;
      else if ((r_state == ST_DATA) && (i_vpos == r_vstop))
        w_state_nxt = ST_CTRL;
      else if ((r_state == ST_WAIT) && (i_vpos == r_vstart) && (r_vstart != r_vstop))
        w_state_nxt = ST_DATA;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vstart   <= 9'd0;
      r_vstop    <= 9'd0;
      r_pos_zero <= 1'b0;
    end else if (i_ack && (r_state == ST_CTRL)) begin
      if (i_ack_code == c_reg_pos) begin
        r_vstart[7:0] <= i_ack_data[15:8];
        r_pos_zero    <= (i_ack_data == 16'h0000);
      end else if (i_ack_code == c_reg_ctl) begin
        r_vstop[7:0] <= i_ack_data[15:8];
        r_vstart[8]  <= i_ack_data[2];
        r_vstop[8]   <= i_ack_data[1];
      end
    end
  end

  // A CPU write in the same cycle as a fetch suppresses the increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_ptr        <= 19'd0;
    else if (i_ptr_wr_hi) r_ptr[18:15] <= i_ptr_data[3:0];
    else if (i_ptr_wr_lo) r_ptr[14:0]  <= i_ptr_data[14:0];
    else if (i_fetch)     r_ptr        <= r_ptr + 19'd1;
  end

endmodule
`default_nettype wire

// File: rtl/sprdma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprdma : sprite DMA sequencer - slot decode, fetch tracking, reg writes    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sprdma
  import sprdma_pkg::*;
#(
  parameter int         NSPR      = 8,
  parameter logic [8:0] SLOT_BASE = 9'h015,
  parameter logic [8:0] VBL_END   = 9'd25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cck,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        spr_en,
  input  logic        ptr_wr,
  input  logic [3:0]  ptr_sel,
  input  logic [15:0] ptr_data,
  output logic        dma_req,
  output logic [18:0] dma_ptr,
  input  logic        dma_ack,
  input  logic [15:0] dma_data,
  output logic        spr_aen,
  output logic [2:0]  spr_num,
  output logic [1:0]  spr_address,
  output logic [15:0] spr_data
);

  localparam logic [8:0] c_slot_span = 9'(NSPR * 4);

  logic [8:0]  w_ofs;
  logic        w_in_window;
  logic        w_slot_b;
  logic [2:0]  w_slot_chan;
  logic        w_line_eval;
  logic        w_fetch_go;
  logic        w_ack_go;
  logic [1:0]  w_fetch_code;
  spr_state_t  w_sel_state;
  logic [18:0] w_sel_ptr;
  spr_state_t  w_state [NSPR];
  logic [18:0] w_ptr   [NSPR];
  logic        r_pend;
  logic [2:0]  r_pend_chan;
  logic [1:0]  r_pend_code;

  // Slots are 4 colour clocks apart per channel, slot B two after slot A.
  assign w_ofs       = hpos - SLOT_BASE;
  assign w_in_window = (hpos >= SLOT_BASE) && (w_ofs < c_slot_span) && !w_ofs[0];
  assign w_slot_chan = w_ofs[4:2];
  assign w_slot_b    = w_ofs[1];
  assign w_line_eval = cck && (hpos == 9'd0);
  assign w_sel_state = w_state[w_slot_chan];
  assign w_sel_ptr   = w_ptr[w_slot_chan];
  assign w_fetch_go  = cck && spr_en && w_in_window &&
                       ((w_sel_state == ST_CTRL) || (w_sel_state == ST_DATA));
  assign w_ack_go    = dma_ack && r_pend;

  // DATB is fetched in slot A so the shifter arms on the later DATA write.
  always_comb begin
    w_fetch_code = w_slot_b ? c_reg_data : c_reg_datb;
    if (w_sel_state == ST_CTRL)
      w_fetch_code = w_slot_b ? c_reg_ctl : c_reg_pos;
  end

  for (genvar i = 0; i < NSPR; i++) begin : g_chan
    sprdma_chan #(.VBL_END(VBL_END)) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_line_eval (w_line_eval),
      .i_vpos      (vpos),
      .i_fetch     (w_fetch_go && (w_slot_chan == 3'(i))),
      .i_ptr_wr_lo (ptr_wr && (ptr_sel[3:1] == 3'(i)) && !ptr_sel[0]),
      .i_ptr_wr_hi (ptr_wr && (ptr_sel[3:1] == 3'(i)) &&  ptr_sel[0]),
      .i_ptr_data  (ptr_data),
      .i_ack       (w_ack_go && (r_pend_chan == 3'(i))),
      .i_ack_code  (r_pend_code),
      .i_ack_data  (dma_data),
      .o_state     (w_state[i]),
      .o_ptr       (w_ptr[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_req     <= 1'b0;
      dma_ptr     <= 19'd0;
      r_pend      <= 1'b0;
      r_pend_chan <= 3'd0;
      r_pend_code <= 2'd0;
      spr_aen     <= 1'b0;
      spr_num     <= 3'd0;
      spr_address <= 2'd0;
      spr_data    <= 16'd0;
    end else begin
      dma_req <= w_fetch_go;
      spr_aen <= w_ack_go;
      if (w_fetch_go) begin
        dma_ptr     <= w_sel_ptr;
        r_pend      <= 1'b1;
        r_pend_chan <= w_slot_chan;
        r_pend_code <= w_fetch_code;
      end else if (w_ack_go) begin
        r_pend <= 1'b0;
      end
      if (w_ack_go) begin
        spr_num     <= r_pend_chan;
        spr_address <= r_pend_code;
        spr_data    <= dma_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprdma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sprdma : self-checking bench for the sprite DMA sequencer               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sprdma;

  localparam int NSPR = 8;
  localparam int SLOT_BASE = 21;
  localparam int VBL_END = 25;
  localparam int M_CTRL = 0, M_WAIT = 1, M_DATA = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cck = 1'b0;
  logic [8:0]  hpos = 9'd0;
  logic [8:0]  vpos = 9'd0;
  logic        spr_en = 1'b0;
  logic        ptr_wr = 1'b0;
  logic [3:0]  ptr_sel = 4'd0;
  logic [15:0] ptr_data = 16'd0;
  logic        dma_ack = 1'b0;
  logic [15:0] dma_data = 16'd0;
  logic        dma_req;
  logic [18:0] dma_ptr;
  logic        spr_aen;
  logic [2:0]  spr_num;
  logic [1:0]  spr_address;
  logic [15:0] spr_data;

  sprdma dut (
    .clk(clk), .reset_n(reset_n), .cck(cck), .hpos(hpos), .vpos(vpos),
    .spr_en(spr_en), .ptr_wr(ptr_wr), .ptr_sel(ptr_sel), .ptr_data(ptr_data),
    .dma_req(dma_req), .dma_ptr(dma_ptr), .dma_ack(dma_ack), .dma_data(dma_data),
    .spr_aen(spr_aen), .spr_num(spr_num), .spr_address(spr_address), .spr_data(spr_data)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  logic [15:0] mem [int];
  int m_state [NSPR];
  int m_vstart [NSPR];
  int m_vstop [NSPR];
  int m_ptr [NSPR];
  int m_posw [NSPR];
  int req_cnt [NSPR];
  int seen0 [$];
  int seen5 [$];

  function automatic logic [15:0] mem_rd(int a);
    if (mem.exists(a)) return mem[a];
    return 16'(a) ^ 16'h5A5A;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_ptr(int c, bit hi, int p);
    ptr_wr = 1'b1;
    ptr_sel = {3'(c), hi};
    ptr_data = hi ? 16'((p >> 15) & 'hF) : 16'(p & 'h7FFF);
    if (hi) m_ptr[c] = (m_ptr[c] & 'h7FFF) | (((p >> 15) & 'hF) << 15);
    else    m_ptr[c] = (m_ptr[c] & 'h78000) | (p & 'h7FFF);
    @(posedge clk); #1;
    ptr_wr = 1'b0;
  endtask

  // One colour clock: strobe cck, check the request, serve it, check the write.
  task automatic tick(int h, int v);
    int ch, code, exp_addr, wc;
    bit slot_b, in_win, exp_req;
    logic [15:0] d;
    hpos = 9'(h); vpos = 9'(v); cck = 1'b1;
    exp_req = 0; exp_addr = 0; code = 0;
    if (h == 0) begin
      for (int c = 0; c < NSPR; c++) begin
        if (v == VBL_END) m_state[c] = M_CTRL;
        else if (m_state[c] == M_DATA && v == m_vstop[c]) m_state[c] = M_CTRL;
        else if (m_state[c] == M_WAIT && v == m_vstart[c] && m_vstart[c] != m_vstop[c])
          m_state[c] = M_DATA;
      end
    end
    in_win = (h >= SLOT_BASE) && (h < SLOT_BASE + 4 * NSPR) && ((h - SLOT_BASE) % 2 == 0);
    ch = in_win ? (h - SLOT_BASE) / 4 : 0;
    slot_b = ((h - SLOT_BASE) % 4) == 2;
    if (spr_en && in_win && (m_state[ch] == M_CTRL || m_state[ch] == M_DATA)) begin
      exp_req = 1;
      exp_addr = m_ptr[ch];
      if (m_state[ch] == M_CTRL) code = slot_b ? 1 : 0;
      else code = slot_b ? 2 : 3;
      if (!(ptr_wr && int'(ptr_sel[3:1]) == ch)) m_ptr[ch] = (m_ptr[ch] + 1) % (1 << 19);
    end
    if (ptr_wr) begin
      wc = int'(ptr_sel[3:1]);
      if (ptr_sel[0]) m_ptr[wc] = (m_ptr[wc] & 'h7FFF) | (int'(ptr_data[3:0]) << 15);
      else            m_ptr[wc] = (m_ptr[wc] & 'h78000) | int'(ptr_data[14:0]);
    end
    @(posedge clk); #1;
    cck = 1'b0; ptr_wr = 1'b0;
    check("dma_req", 32'(dma_req), 32'(exp_req));
    if (dma_req === 1'b1 && in_win) begin
      req_cnt[ch]++;
      if (ch == 0) seen0.push_back(int'(dma_ptr));
      if (ch == 5) seen5.push_back(int'(dma_ptr));
    end
    if (exp_req) begin
      check("dma_ptr", 32'(dma_ptr), 32'(exp_addr));
      d = mem_rd(exp_addr);
      dma_ack = 1'b1; dma_data = d;
      @(posedge clk); #1;
      dma_ack = 1'b0;
      check("spr_aen", 32'(spr_aen), 32'd1);
      check("spr_num", 32'(spr_num), 32'(ch));
      check("spr_address", 32'(spr_address), 32'(code));
      check("spr_data", 32'(spr_data), 32'(d));
      if (code == 0) begin
        m_vstart[ch] = (m_vstart[ch] & 'h100) | int'(d[15:8]);
        m_posw[ch] = int'(d);
      end else if (code == 1) begin
        m_vstop[ch] = (int'(d[1]) << 8) | int'(d[15:8]);
        m_vstart[ch] = (int'(d[2]) << 8) | (m_vstart[ch] & 'hFF);
        m_state[ch] = (m_posw[ch] == 0 && d == 16'h0) ? M_DONE : M_WAIT;
      end
    end else begin
      @(posedge clk); #1;
      check("spr_aen idle", 32'(spr_aen), 32'd0);
    end
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, " dma_req"}, 32'(dma_req), 32'd0);
    check({tag, " dma_ptr"}, 32'(dma_ptr), 32'd0);
    check({tag, " spr_aen"}, 32'(spr_aen), 32'd0);
    check({tag, " spr_num"}, 32'(spr_num), 32'd0);
    check({tag, " spr_address"}, 32'(spr_address), 32'd0);
    check({tag, " spr_data"}, 32'(spr_data), 32'd0);
  endtask

  initial begin
    int p, vs, len;
    int ptrs [NSPR];

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    for (int c = 0; c < NSPR; c++) begin
      m_state[c] = M_DONE; m_vstart[c] = 0; m_vstop[c] = 0;
      m_ptr[c] = 0; m_posw[c] = 0; req_cnt[c] = 0;
    end

    // memory image
    mem[32'h1000] = 16'h3040; mem[32'h1001] = 16'h3200;
    for (int k = 2; k < 6; k++) mem[32'h1000 + k] = 16'($urandom);
    mem[32'h1006] = 16'h0000; mem[32'h1007] = 16'h0000;
    mem[32'h1100] = 16'h4000; mem[32'h1101] = 16'h4000;
    mem[32'h1300] = 16'h0000; mem[32'h1301] = 16'h0000;
    mem[32'h5000] = 16'($urandom_range(26, 60) << 8);
    mem[32'h2345] = 16'($urandom_range(30, 66) << 8);
    ptrs[0] = 'h1000; ptrs[1] = 'h1100; ptrs[3] = 'h1300; ptrs[5] = 'h5000;
    ptrs[2] = 'h1200; ptrs[4] = 'h1400; ptrs[6] = 'h1600; ptrs[7] = 'h41700;
    for (int c = 2; c < NSPR; c++) begin
      if (c == 3 || c == 5) continue;
      p = ptrs[c];
      vs = $urandom_range(26, 60);
      len = $urandom_range(1, 3);
      mem[p] = 16'(vs << 8);
      mem[p + 1] = 16'(((vs + len) & 'hFF) << 8);
      for (int k = 0; k < 2 * len; k++) mem[p + 2 + k] = 16'($urandom);
    end
    for (int c = 0; c < NSPR; c++) begin
      wr_ptr(c, 1'b1, ptrs[c]);
      wr_ptr(c, 1'b0, ptrs[c]);
    end

    // one frame, with sprite DMA paused for lines 0x34..0x36
    for (int v = VBL_END; v <= 70; v++) begin
      for (int h = 0; h < 64; h++) begin
        spr_en = !(v >= 'h34 && v <= 'h36);
        if (v == VBL_END && h == SLOT_BASE + 20) begin
          ptr_wr = 1'b1; ptr_sel = {3'd5, 1'b0}; ptr_data = 16'h2345;
        end
        tick(h, v);
      end
    end

    // directed outcomes of the frame
    check("ch0 fetch count", 32'(seen0.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < seen0.size()) check("ch0 fetch addr", 32'(seen0[i]), 32'h1000 + 32'(i));
    check("ch5 fetch count>=2", 32'(seen5.size() >= 2), 32'd1);
    if (seen5.size() >= 2) begin
      check("ch5 first addr", 32'(seen5[0]), 32'h5000);
      check("ch5 ptr_wr wins", 32'(seen5[1]), 32'h2345);
    end
    check("ch1 equal start/stop fetches", 32'(req_cnt[1]), 32'd2);
    check("ch3 done fetches", 32'(req_cnt[3]), 32'd2);

    // asynchronous reset between request and acknowledge
    spr_en = 1'b1;
    tick(0, VBL_END);
    hpos = 9'(SLOT_BASE); vpos = 9'(VBL_END); cck = 1'b1;
    @(posedge clk); #1;
    cck = 1'b0;
    check("pre-reset dma_req", 32'(dma_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid-fetch reset");
    dma_ack = 1'b1; dma_data = 16'hBEEF;
    @(posedge clk); #1;
    check("spr_aen in reset", 32'(spr_aen), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("stale ack ignored", 32'(spr_aen), 32'd0);
    dma_ack = 1'b0;
    hpos = 9'(SLOT_BASE); vpos = 9'(VBL_END + 1); cck = 1'b1;
    @(posedge clk); #1;
    cck = 1'b0;
    check("no req after reset", 32'(dma_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprdma.md
# sprdma

Sprite DMA sequencer: fetches control and image words for eight sprite channels from chip memory during fixed horizontal DMA slots. It tracks each channel's vertical start/stop line and forwards fetched words as register writes (POS/CTL/DATA/DATB) to the per-sprite shifters downstream. It sits between the chip-bus arbiter and the sprite shifter array, and owns the eight sprite pointer registers.

## Interface
- NSPR, 8, number of sprite channels (fixed at 8; 3-bit channel index)
- SLOT_BASE, 9'h015, hpos of channel 0 slot A; channel n slot A = SLOT_BASE+4n, slot B = SLOT_BASE+4n+2
- VBL_END, 9'd25, first line on which sprite DMA runs; all channels restart here

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cck  in  1  one-cycle strobe per colour clock; hpos/vpos valid when high
- hpos  in  9  horizontal beam position (colour clocks)
- vpos  in  9  vertical beam position (lines)
- spr_en  in  1  sprite DMA enable
- ptr_wr  in  1  CPU pointer write strobe
- ptr_sel  in  4  {channel[2:0], hi/lo}: hi writes ptr[18:15], lo writes ptr[14:0]
- ptr_data  in  16  pointer write data
- dma_req  out  1  one-cycle fetch request
- dma_ptr  out  19  word address of request (byte address [19:1])
- dma_ack  in  1  fetched word valid on dma_data
- dma_data  in  16  fetched word
- spr_aen  out  1  shifter register write strobe
- spr_num  out  3  target sprite channel
- spr_address  out  2  00 POS, 01 CTL, 10 DATA, 11 DATB
- spr_data  out  16  register write data

## Operation
- Per-channel state: CTRL, WAIT, DATA, DONE; plus vstart[8:0], vstop[8:0], ptr[18:0].
- Line evaluation on cck with hpos==0, per channel, in order:
  - vpos==VBL_END: state <= CTRL (overrides all).
  - DATA and vpos==vstop: state <= CTRL.
  - WAIT and vpos==vstart and vstart!=vstop: state <= DATA.
- Slot fetches (cck, spr_en=1, hpos==slot): CTRL fetches POS (slot A) and CTL (slot B); DATA fetches DATB (slot A) and DATA (slot B); WAIT/DONE issue no request.
- dma_req carries dma_ptr=ptr; ptr <= ptr+1 (mod 2^19) on the request cycle.
- On dma_ack: word is forwarded as a register write; in CTRL, POS updates vstart[7:0]=data[15:8]; CTL updates vstop[7:0]=data[15:8], vstart[8]=data[2], vstop[8]=data[1].
- After CTL forwarded: POS and CTL both 0 -> DONE; else -> WAIT.
- Downstream ordering: DATB precedes DATA so the shifter arms on DATA with both words latched.
- ptr_wr updates the selected half immediately; a same-cycle slot increment loses to ptr_wr.
- spr_en low: no new requests, states frozen except line evaluation; an outstanding ack is still forwarded.

## Timing
- Reset: all outputs 0; every channel DONE, ptr=0, vstart=vstop=0.
- dma_req asserted the cycle after the qualifying cck (registered), exactly one cycle.
- dma_ack must arrive before the channel's next slot (≤2 colour clocks); at most one fetch outstanding; ack with none outstanding is ignored.
- spr_aen/spr_num/spr_address/spr_data registered: asserted the cycle after dma_ack, one cycle.
- CTRL->WAIT/DONE transition takes effect the cycle after the CTL write is forwarded.
- Async reset mid-fetch discards the outstanding fetch; no spr_aen follows.

## Structure
- Package sprdma_pkg: state enum (CTRL/WAIT/DATA/DONE), register codes POS/CTL/DATA/DATB, slot offsets.
- Sub-module sprdma_chan: one channel's state, vstart/vstop, pointer; instantiated NSPR times. Top holds slot decode, single outstanding-fetch tracker, output registers.

## Test plan
- Reset, VBL_END line, ch0 ptr=0x01000, memory POS=0x3040 CTL=0x3200 -> reqs at 0x01000/0x01001, spr_aen POS then CTL, ch0 WAIT, vstart=0x30, vstop=0x32.
- Continue to line 0x30 -> DATB at 0x01002 then DATA at 0x01003 on lines 0x30,0x31; line 0x32 fetches next POS/CTL at 0x01006.
- POS=CTL=0 -> ch3 DONE, no further reqs until next VBL_END.
- vstart==vstop=0x40 -> channel stays WAIT, no DATA fetches on line 0x40.
- ptr_wr to ch5 lo on same cycle as its slot request -> pointer holds written value, not written+1.
- reset_n low between dma_req and dma_ack -> no spr_aen; all outputs 0 during reset.
